ahb_apb_bridge_p: RTL and testbench

Parametrised AHB-Lite slave to APB4 master bridge.
- Successor to the fixed 4-slave, 32-bit AHB2APB bridge.
- Generalises address/data width and slave count.
- Adds PREADY wait states, PSLVERR-to-HRESP error mapping, byte strobes, an address-decode error path and an APB access timeout.
- Sits between the AHB interconnect and the peripheral APB slaves.

---
 rtl/ahb_apb_pkg.sv | 46 ++++
 rtl/ahb_apb_decoder.sv | 50 +++++
 rtl/ahb_apb_bridge_p.sv | 154 +++++++++++++++
 tb/tb_ahb_apb_bridge_p.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-Lite to APB4 bridge.
// Holds the AHB transfer/response encodings, the bridge FSM state type and the
// byte-strobe generator used when a write is launched onto APB.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are answered OKAY.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

  // Byte lanes [addr_lo +: 2**size], sized for the widest (64-bit) bus.
  function automatic logic [7:0] strb_gen(input logic [2:0] size, input logic [2:0] addr_lo);
    logic [7:0] mask;
    case (size)
      3'd0:    mask = 8'h01;
      3'd1:    mask = 8'h03;
      3'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << addr_lo;
  endfunction

endpackage

// File: rtl/ahb_apb_decoder.sv
// Combinational address decoder for the bridge.
// Ports: addr/size  - AHB address and transfer size of the candidate transfer
//        sel_c      - one-hot slave select (all zero when invalid)
//        valid_c    - base region hit, slave index in range, size fits the bus
//                     and address aligned to the size
module ahb_apb_decoder
  import ahb_apb_pkg::*;
#(
  parameter int unsigned             ADDR_W    = 32,
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             NSLV      = 4,
  parameter int unsigned             REGION_W  = 12,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = ADDR_W'(32'h8000_0000)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  output logic [NSLV-1:0]   sel_c,
  output logic              valid_c
);

  localparam int unsigned IDX_W   = $clog2(NSLV);
  localparam int unsigned TAG_LSB = REGION_W + IDX_W;

  logic [ADDR_W-1:0] idx_full;
  logic [ADDR_W-1:0] tag;
  logic [ADDR_W-1:0] base_tag;
  logic [ADDR_W-1:0] align_mask;
  logic              base_hit;
  logic              idx_ok;
  logic              size_ok;
  logic              aligned;

  // Shifts instead of part-selects so NSLV=1 (zero index bits) stays legal.
  always_comb begin
    idx_full   = (addr >> REGION_W) & ADDR_W'((64'd1 << IDX_W) - 64'd1);
    tag        = addr >> TAG_LSB;
    base_tag   = BASE_ADDR >> TAG_LSB;
    base_hit   = (tag == base_tag);
    idx_ok     = (idx_full < ADDR_W'(NSLV));
    size_ok    = ((32'd8 << size) <= DATA_W);
    align_mask = ADDR_W'((32'd1 << size) - 32'd1);
    aligned    = ((addr & align_mask) == '0);
    valid_c    = base_hit && idx_ok && size_ok && aligned;
    sel_c      = '0;
    if (valid_c) begin
      sel_c = NSLV'(1) << idx_full;
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// Parametrised AHB-Lite slave to APB4 master bridge.
// AHB side: Hwrite/Hreadyin/Htrans/Haddr/Hwdata/Hsize/Hburst in,
//           Hreadyout/Hresp/Hrdata out (ERROR uses the two-cycle response).
// APB side: Psel (one-hot)/Penable/Pwrite/Paddr/Pwdata/Pstrb out,
//           Prdata/Pready/Pslverr in. Optional ACCESS-phase timeout.
// clk is shared by both buses; Hrstn is an asynchronous active-low reset.
module ahb_apb_bridge_p
  import ahb_apb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NSLV      = 4,
  parameter int unsigned       REGION_W  = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int unsigned       TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                Hrstn,
  input  logic                Hwrite,
  input  logic                Hreadyin,
  input  logic [1:0]          Htrans,
  input  logic [ADDR_W-1:0]   Haddr,
  input  logic [DATA_W-1:0]   Hwdata,
  input  logic [2:0]          Hsize,
  input  logic [2:0]          Hburst,
  output logic                Hreadyout,
  output logic [1:0]          Hresp,
  output logic [DATA_W-1:0]   Hrdata,
  output logic [NSLV-1:0]     Psel,
  output logic                Penable,
  output logic                Pwrite,
  output logic [ADDR_W-1:0]   Paddr,
  output logic [DATA_W-1:0]   Pwdata,
  output logic [DATA_W/8-1:0] Pstrb,
  input  logic [DATA_W-1:0]   Prdata,
  input  logic                Pready,
  input  logic                Pslverr
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned LO_W    = $clog2(STRB_W);
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  bridge_state_e     state_q;
  bridge_state_e     state_d;
  logic [NSLV-1:0]   sel_q;
  logic [2:0]        hsize_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NSLV-1:0]   dec_sel_c;
  logic              dec_valid_c;
  logic              capture_c;
  logic              can_capture_c;
  logic              unused_hburst;

  // Bursts are split into independent singles, so the burst type is ignored.
  assign unused_hburst = ^Hburst;

  ahb_apb_decoder #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NSLV      (NSLV),
    .REGION_W  (REGION_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_dec (
    .addr    (Haddr),
    .size    (Hsize),
    .sel_c   (dec_sel_c),
    .valid_c (dec_valid_c)
  );

  assign can_capture_c = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign capture_c     = can_capture_c && Hreadyin && htrans_active(Htrans);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (capture_c) begin
          state_d = dec_valid_c ? ST_LATCH : ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (Pready) begin
          state_d = Pslverr ? ST_ERR1 : ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; bus outputs are registered from the next state so they
  // line up with the state they belong to.
  always_ff @(posedge clk or negedge Hrstn) begin
    if (!Hrstn) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      hsize_q   <= '0;
      cnt_q     <= '0;
      Hreadyout <= 1'b1;
      Hresp     <= HRESP_OKAY;
      Hrdata    <= '0;
      Psel      <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pstrb     <= '0;
    end else begin
      state_q   <= state_d;
      Hreadyout <= (state_d == ST_IDLE) || (state_d == ST_ERR2);
      Hresp     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      Psel      <= ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) ? sel_q : '0;
      Penable   <= (state_d == ST_ACCESS);

      // Address phase: Paddr doubles as the captured AHB address.
      if (capture_c) begin
        Paddr   <= Haddr;
        Pwrite  <= Hwrite;
        hsize_q <= Hsize;
        sel_q   <= dec_sel_c;
      end

      // Data phase: write data is only valid on the bus during LATCH.
      if (state_q == ST_LATCH) begin
        if (Pwrite) begin
          Pwdata <= Hwdata;
          Pstrb  <= STRB_W'(strb_gen(hsize_q, 3'(Paddr[LO_W-1:0])));
        end else begin
          Pstrb  <= '0;
        end
      end

      if (state_d == ST_SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ST_ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if ((state_q == ST_ACCESS) && Pready && !Pslverr && !Pwrite) begin
        Hrdata <= Prdata;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Scoreboard bench for ahb_apb_bridge_p: a default 4-slave instance plus a
// 3-slave instance sharing the same AHB stimulus and APB slave model.
module tb_ahb_apb_bridge_p;

  logic        clk = 1'b0;
  logic        Hrstn;
  logic        Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata;
  logic [2:0]  Hsize, Hburst;
  logic        Hreadyout, Penable, Pwrite;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata, Paddr, Pwdata, Prdata;
  logic [3:0]  Psel, Pstrb;
  logic        Pready, Pslverr;

  logic        h3_ready, pen3, pwr3;
  logic [1:0]  h3_resp;
  logic [31:0] h3_rdata, paddr3, pwdata3;
  logic [2:0]  psel3;
  logic [3:0]  pstrb3;

  always #5 clk = ~clk;

  ahb_apb_bridge_p u_dut (
    .clk(clk), .Hrstn(Hrstn), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Hsize(Hsize), .Hburst(Hburst),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata), .Psel(Psel), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Pstrb(Pstrb), .Prdata(Prdata),
    .Pready(Pready), .Pslverr(Pslverr)
  );

  ahb_apb_bridge_p #(.NSLV(3)) u_dut3 (
    .clk(clk), .Hrstn(Hrstn), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Hsize(Hsize), .Hburst(Hburst),
    .Hreadyout(h3_ready), .Hresp(h3_resp), .Hrdata(h3_rdata), .Psel(psel3), .Penable(pen3),
    .Pwrite(pwr3), .Paddr(paddr3), .Pwdata(pwdata3), .Pstrb(pstrb3), .Prdata(Prdata),
    .Pready(Pready), .Pslverr(Pslverr)
  );

  // APB slave model: ready after wait_cyc stalled ACCESS cycles.
  int          wait_cyc = 0;
  logic        serr = 1'b0;
  logic [31:0] rd_val = '0;
  int          acc_seen;

  always @(posedge clk or negedge Hrstn) begin
    if (!Hrstn) acc_seen <= 0;
    else if ((Psel != 0) && Penable && !Pready) acc_seen <= acc_seen + 1;
    else acc_seen <= 0;
  end
  assign Pready  = Penable && (acc_seen >= wait_cyc);
  assign Pslverr = serr && Pready;
  assign Prdata  = rd_val;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          low;
    logic        err;
    logic [3:0]  psel;
    logic [3:0]  pstrb;
    int          acc;
    logic [31:0] rdata;
    int          low3;
    logic        err3;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor state
  int          low_cnt, acc_cnt, low3, d3_low;
  logic        setup_seen, apb3, d3_apb, d3_done;
  logic [1:0]  resp_low, d3_resp;
  logic [3:0]  m_psel, m_pstrb;
  logic [31:0] m_paddr, m_pwdata;
  logic        m_pwrite;

  initial begin : monitor
    exp_t e;
    low_cnt = 0; acc_cnt = 0; low3 = 0; d3_low = 0;
    setup_seen = 0; apb3 = 0; d3_apb = 0; d3_done = 0; resp_low = 0; d3_resp = 0;
    m_psel = 0; m_pstrb = 0; m_paddr = 0; m_pwdata = 0; m_pwrite = 0;
    forever begin
      @(negedge clk);
      if (!Hrstn) begin
        low_cnt = 0; acc_cnt = 0; low3 = 0; setup_seen = 0; apb3 = 0; d3_done = 0;
      end else begin
        // 3-slave instance: remember its last completed transfer
        if (!h3_ready) begin
          low3++;
          if (psel3 != 0) apb3 = 1;
        end else if (low3 > 0) begin
          d3_low = low3; d3_resp = h3_resp; d3_apb = apb3; d3_done = 1;
          low3 = 0; apb3 = 0;
        end
        // main instance
        if (!Hreadyout) begin
          low_cnt++;
          resp_low = Hresp;
          if ((Psel != 0) && !Penable && !setup_seen) begin
            setup_seen = 1;
            m_psel = Psel; m_paddr = Paddr; m_pwrite = Pwrite; m_pwdata = Pwdata; m_pstrb = Pstrb;
          end
          if ((Psel != 0) && Penable) acc_cnt++;
        end else if (low_cnt > 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("hready_low_cycles", low_cnt, e.low);
            chk("hresp_final", Hresp, e.err ? 2'b01 : 2'b00);
            chk("hresp_last_low", resp_low, e.err ? 2'b01 : 2'b00);
            chk("apb_activity", setup_seen, (e.low > 1));
            if (setup_seen) begin
              chk("psel", m_psel, e.psel);
              chk("paddr", m_paddr, e.addr);
              chk("pwrite", m_pwrite, e.wr);
              chk("pstrb", m_pstrb, e.pstrb);
              if (e.wr) chk("pwdata", m_pwdata, e.wdata);
              chk("access_cycles", acc_cnt, e.acc);
            end
            chk("hrdata", Hrdata, e.rdata);
            chk("apb_idle_after", {Psel, Penable}, 5'b0);
            chk("n3_done", d3_done, 1);
            chk("n3_low_cycles", d3_low, e.low3);
            chk("n3_hresp", d3_resp, e.err3 ? 2'b01 : 2'b00);
            chk("n3_apb_activity", d3_apb, (e.low3 > 1));
          end
          low_cnt = 0; acc_cnt = 0; setup_seen = 0; d3_done = 0;
        end
      end
    end
  end

  // One AHB single transfer; caller is away from the rising edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input int wait_c, input logic slverr,
                      input logic [31:0] prd, input int e_low, input logic e_err,
                      input logic [3:0] e_psel, input logic [3:0] e_pstrb, input int e_acc,
                      input logic [31:0] e_rdata, input int e_low3, input logic e_err3);
    exp_t e;
    bit   done;
    e = '{wr: wr, addr: addr, wdata: wdata, low: e_low, err: e_err, psel: e_psel,
          pstrb: e_pstrb, acc: e_acc, rdata: e_rdata, low3: e_low3, err3: e_err3};
    exp_q.push_back(e);
    wait_cyc = wait_c; serr = slverr; rd_val = prd;
    Hwrite = wr; Haddr = addr; Hsize = size; Htrans = 2'b10; Hreadyin = 1'b1;
    @(posedge clk); #1;
    Htrans = 2'b00; Hwdata = wdata;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Hreadyout) begin done = 1; break; end
    end
    if (!done) chk("xfer_completes", 0, 1);
  endtask

  initial begin : guard
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    bit found;
    Hrstn = 1'b0; Hwrite = 0; Hreadyin = 1; Htrans = 2'b00; Haddr = '0; Hwdata = '0;
    Hsize = 3'd2; Hburst = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_hreadyout", Hreadyout, 1);
    chk("rst_hresp", Hresp, 0);
    chk("rst_hrdata", Hrdata, 0);
    chk("rst_psel_penable", {Psel, Penable, Pwrite}, 0);
    chk("rst_paddr_pwdata", {Paddr, Pwdata}, 0);
    chk("rst_pstrb", Pstrb, 0);
    Hrstn = 1'b1;
    @(negedge clk);

    // wr/addr/size/wdata/wait/slverr/prdata | low/err/psel/pstrb/acc/rdata/low3/err3
    xfer(1, 32'h8000_1004, 3'd2, 32'hDEAD_BEEF, 0, 0, 32'h0,
         3, 0, 4'b0010, 4'b1111, 1, 32'h0, 3, 0);
    xfer(0, 32'h8000_3000, 3'd2, 32'h0, 2, 0, 32'h1234_5678,
         5, 0, 4'b1000, 4'b0000, 3, 32'h1234_5678, 1, 1);
    xfer(1, 32'h8000_0002, 3'd0, 32'h00AB_0000, 0, 0, 32'h0,
         3, 0, 4'b0001, 4'b0100, 1, 32'h1234_5678, 3, 0);
    xfer(1, 32'h8000_0001, 3'd1, 32'h1111_2222, 0, 0, 32'h0,
         1, 1, 4'b0000, 4'b0000, 0, 32'h1234_5678, 1, 1);
    xfer(0, 32'h9000_0000, 3'd2, 32'h0, 0, 0, 32'hFFFF_FFFF,
         1, 1, 4'b0000, 4'b0000, 0, 32'h1234_5678, 1, 1);
    xfer(0, 32'h8000_0000, 3'd3, 32'h0, 0, 0, 32'hFFFF_FFFF,
         1, 1, 4'b0000, 4'b0000, 0, 32'h1234_5678, 1, 1);
    xfer(1, 32'h8000_2008, 3'd2, 32'hA5A5_0F0F, 0, 1, 32'h0,
         4, 1, 4'b0100, 4'b1111, 1, 32'h1234_5678, 4, 1);
    xfer(0, 32'h8000_000C, 3'd2, 32'h0, 255, 0, 32'hBAD0_BAD0,
         19, 1, 4'b0001, 4'b0000, 16, 32'h1234_5678, 19, 1);
    xfer(0, 32'h8000_1012, 3'd1, 32'h0, 1, 0, 32'hCAFE_0000,
         4, 0, 4'b0010, 4'b0000, 2, 32'hCAFE_0000, 4, 0);
    xfer(1, 32'h8000_1006, 3'd1, 32'hBEEF_0000, 0, 0, 32'h0,
         3, 0, 4'b0010, 4'b1100, 1, 32'hCAFE_0000, 3, 0);

    // Reset in the middle of a stalled ACCESS phase
    wait_cyc = 255; serr = 0; rd_val = '0;
    Hwrite = 0; Haddr = 32'h8000_1000; Hsize = 3'd2; Htrans = 2'b10; Hreadyin = 1;
    @(posedge clk); #1;
    Htrans = 2'b00;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Penable) begin found = 1; break; end
    end
    chk("rst_test_reaches_access", found, 1);
    @(posedge clk); #2;
    Hrstn = 1'b0;
    #1;
    chk("midrst_psel_penable", {Psel, Penable}, 5'b0);
    chk("midrst_hreadyout_hresp", {Hreadyout, Hresp}, 3'b100);
    chk("midrst_n3_psel_penable", {psel3, pen3}, 4'b0);
    repeat (2) @(posedge clk);
    #2;
    Hrstn = 1'b1;
    @(negedge clk);
    wait_cyc = 0;

    xfer(1, 32'h8000_3FFC, 3'd2, 32'h5A5A_A5A5, 0, 0, 32'h0,
         3, 0, 4'b1000, 4'b1111, 1, 32'h0, 1, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
